// File: rtl/polybius_code_serializer_if.sv
// Code-block input channel and character output channel of the Polybius serializer,
// together with its busy/code_err status lines.
interface polybius_code_serializer_if #(
    parameter int MSG_LEN = 7
);
    logic       blk_valid;
    logic       blk_ready;
    logic [7:0] blk_data [0:MSG_LEN-1];
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_last;
    logic       busy;
    logic       code_err;

    modport master (
        output blk_valid, blk_data, out_ready,
        input  blk_ready, out_valid, out_char, out_last, busy, code_err
    );

    modport slave (
        input  blk_valid, blk_data, out_ready,
        output blk_ready, out_valid, out_char, out_last, busy, code_err
    );
endinterface

// File: rtl/polybius_code_serializer.sv
// Serializes a block of MSG_LEN Polybius codes (row*10+col) into ASCII digit pairs,
// optionally separated by SEP_CHAR; invalid codes print as "??" and raise a sticky flag.
module polybius_code_serializer #(
    parameter int         MSG_LEN  = 7,
    parameter bit         ADD_SEP  = 1'b1,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input logic                  clk,
    input logic                  rst,
    polybius_code_serializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HI, LO, SEP} state_t;

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] index, index_next;
    logic [7:0]       code_buf [0:MSG_LEN-1];
    logic             load;
    logic             fire;
    logic [7:0]       cur_code, tens, units;
    logic             code_ok;
    logic             code_err_q;

    assign cur_code = code_buf[index];
    assign tens     = cur_code / 8'd10;
    assign units    = cur_code % 8'd10;
    // Codes 100..255 give tens >= 10 and so fall out of the 1..5 window naturally.
    assign code_ok  = (tens >= 8'd1) && (tens <= 8'd5) && (units >= 8'd1) && (units <= 8'd5);
    assign fire     = (state != IDLE) && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            index      <= '0;
            code_err_q <= 1'b0;
            for (int unsigned i = 0; i < MSG_LEN; i++) code_buf[i] <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
            if (load) begin
                for (int unsigned i = 0; i < MSG_LEN; i++) code_buf[i] <= bus.blk_data[i];
                code_err_q <= 1'b0;
            end else if (state == HI && !code_ok) begin
                code_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.blk_valid) begin
                    load       = 1'b1;
                    index_next = '0;
                    state_next = HI;
                end
            end
            HI: begin
                if (fire) state_next = LO;
            end
            LO: begin
                if (fire) begin
                    if (index == LAST_IDX) begin
                        state_next = IDLE;
                    end else if (ADD_SEP) begin
                        state_next = SEP;
                    end else begin
                        index_next = index + IDX_W'(1);
                        state_next = HI;
                    end
                end
            end
            SEP: begin
                if (fire) begin
                    index_next = index + IDX_W'(1);
                    state_next = HI;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.out_char = '0;
        unique case (state)
            HI:      bus.out_char = code_ok ? (8'h30 + tens)  : 8'h3F;
            LO:      bus.out_char = code_ok ? (8'h30 + units) : 8'h3F;
            SEP:     bus.out_char = SEP_CHAR;
            default: bus.out_char = '0;
        endcase
    end

    assign bus.out_valid = (state != IDLE);
    assign bus.out_last  = (state == LO) && (index == LAST_IDX);
    assign bus.blk_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.code_err  = code_err_q;
endmodule

// File: tb/tb_polybius_code_serializer.sv
// Directed bench for polybius_code_serializer: one instance with separators, one without.
module tb_polybius_code_serializer;
    typedef struct {
        bit         sel;       // 0: separator instance, 1: digits-only instance
        bit         rnd;       // pseudo-random out_ready
        logic [7:0] codes [7];
        string      exp;
        int         bad;       // index of first invalid code, 7 if none
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic bv  = 1'b0;
    logic out_rdy = 1'b1;
    logic [7:0] bd [0:6];

    vec_t vt [8];
    int   nv = 0;
    int   ncmp = 0;
    int   nerr = 0;

    polybius_code_serializer_if #(.MSG_LEN(7)) ia ();
    polybius_code_serializer_if #(.MSG_LEN(7)) ib ();

    polybius_code_serializer #(.MSG_LEN(7), .ADD_SEP(1'b1), .SEP_CHAR(8'h20)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );
    polybius_code_serializer #(.MSG_LEN(7), .ADD_SEP(1'b0), .SEP_CHAR(8'h20)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave)
    );

    assign ia.blk_valid = bv && !sel;
    assign ib.blk_valid = bv && sel;
    assign ia.blk_data  = bd;
    assign ib.blk_data  = bd;
    assign ia.out_ready = out_rdy;
    assign ib.out_ready = out_rdy;

    logic       c_valid, c_last, c_bready, c_busy, c_err;
    logic [7:0] c_char;
    assign c_valid  = sel ? ib.out_valid : ia.out_valid;
    assign c_last   = sel ? ib.out_last  : ia.out_last;
    assign c_bready = sel ? ib.blk_ready : ia.blk_ready;
    assign c_busy   = sel ? ib.busy      : ia.busy;
    assign c_err    = sel ? ib.code_err  : ia.code_err;
    assign c_char   = sel ? ib.out_char  : ia.out_char;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input bit s, input bit r,
                           input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                           input logic [7:0] c3, input logic [7:0] c4, input logic [7:0] c5,
                           input logic [7:0] c6, input string e, input int b);
        vt[nv].sel = s;
        vt[nv].rnd = r;
        vt[nv].codes[0] = c0; vt[nv].codes[1] = c1; vt[nv].codes[2] = c2;
        vt[nv].codes[3] = c3; vt[nv].codes[4] = c4; vt[nv].codes[5] = c5;
        vt[nv].codes[6] = c6;
        vt[nv].exp = e;
        vt[nv].bad = b;
        nv++;
    endtask

    task automatic load_bd(input int vi);
        for (int i = 0; i < 7; i++) bd[i] = vt[vi].codes[i];
    endtask

    task automatic scramble_bd();
        for (int i = 0; i < 7; i++) bd[i] = bd[i] ^ 8'hA5;
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge after acceptance.
    task automatic send(input int vi);
        chk("ready_before_send", {31'b0, c_bready}, 32'd1);
        load_bd(vi);
        bv = 1'b1;
        @(negedge clk);
        bv = 1'b0;
        scramble_bd();
    endtask

    // Streams one block starting in the cycle after acceptance; ends at the first idle negedge.
    task automatic drain(input int vi);
        int    pos = 0;
        int    cyc = 0;
        int    step;
        int    k;
        int    ph;
        bit    stalled = 1'b0;
        bit    rdy;
        logic [7:0] held = '0;
        string e = vt[vi].exp;
        int    len = e.len();
        step = vt[vi].sel ? 2 : 3;
        chk("first_valid", {31'b0, c_valid}, 32'd1);
        while (pos < len && cyc < 300) begin
            rdy = vt[vi].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_rdy = rdy;
            if (c_valid) begin
                if (stalled) chk("hold_char", {24'b0, c_char}, {24'b0, held});
                if (rdy) begin
                    chk("char", {24'b0, c_char}, {24'b0, e[pos]});
                    chk("last", {31'b0, c_last}, {31'b0, (pos == len - 1)});
                    k  = pos / step;
                    ph = pos % step;
                    if (k < vt[vi].bad)
                        chk("err_clear", {31'b0, c_err}, 32'd0);
                    else if (k > vt[vi].bad || ph != 0)
                        chk("err_set", {31'b0, c_err}, 32'd1);
                    pos++;
                    stalled = 1'b0;
                end else begin
                    held    = c_char;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (pos < len) chk("char_count", pos, len);
        out_rdy = 1'b1;
        chk("idle_valid", {31'b0, c_valid}, 32'd0);
        chk("idle_ready", {31'b0, c_bready}, 32'd1);
        chk("final_err", {31'b0, c_err}, {31'b0, (vt[vi].bad < 7)});
    endtask

    initial begin
        for (int i = 0; i < 7; i++) bd[i] = '0;
        set_vec(0, 0, 8'd33, 8'd15, 8'd14, 8'd15, 8'd31, 8'd13, 8'd45, "33 15 14 15 31 13 45", 7);
        set_vec(0, 1, 8'd33, 8'd15, 8'd14, 8'd15, 8'd31, 8'd13, 8'd45, "33 15 14 15 31 13 45", 7);
        set_vec(0, 0, 8'd33, 8'd60, 8'd16, 8'd9,  8'd55, 8'd12, 8'd200, "33 ?? ?? ?? 55 12 ??", 1);
        set_vec(0, 0, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd51, 8'd15, "11 22 33 44 55 51 15", 7);
        set_vec(0, 1, 8'd10, 8'd56, 8'd0,  8'd99, 8'd65, 8'd50, 8'd11, "?? ?? ?? ?? ?? ?? 11", 0);
        set_vec(1, 0, 8'd11, 8'd11, 8'd11, 8'd11, 8'd11, 8'd11, 8'd11, "11111111111111", 7);
        set_vec(1, 1, 8'd54, 8'd45, 8'd32, 8'd23, 8'd11, 8'd55, 8'd21, "54453223115521", 7);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_blk_ready", {31'b0, ia.blk_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, ia.out_valid}, 32'd0);
        chk("rst_out_char",  {24'b0, ia.out_char}, 32'd0);
        chk("rst_out_last",  {31'b0, ia.out_last}, 32'd0);
        chk("rst_busy",      {31'b0, ia.busy}, 32'd0);
        chk("rst_code_err",  {31'b0, ia.code_err}, 32'd0);

        for (int i = 0; i < nv; i++) begin
            sel = vt[i].sel;
            @(negedge clk);
            send(i);
            drain(i);
        end

        // Reset after the 5th character: output must drop at once and the next block start clean.
        sel = 1'b0;
        @(negedge clk);
        send(0);
        repeat (5) @(negedge clk);
        chk("pre_rst_char", {24'b0, ia.out_char}, {24'b0, 8'h20});
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, ia.out_valid}, 32'd0);
        chk("mid_rst_busy",  {31'b0, ia.busy}, 32'd0);
        chk("mid_rst_char",  {24'b0, ia.out_char}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, ia.blk_ready}, 32'd1);
        chk("post_rst_valid", {31'b0, ia.out_valid}, 32'd0);
        send(2);
        drain(2);

        // Back-to-back: valid held with the next block's data while the first is still busy.
        @(negedge clk);
        load_bd(0);
        bv = 1'b1;
        @(negedge clk);
        load_bd(3);
        drain(0);
        @(negedge clk);
        bv = 1'b0;
        scramble_bd();
        chk("b2b_busy", {31'b0, c_busy}, 32'd1);
        drain(3);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/polybius_code_serializer.md
POLYBIUS_CODE_SERIALIZER -- requirements
Module: polybius_code_serializer

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 7, the number of codes per block.
REQ-002 The block SHALL have parameter ADD_SEP, default 1: 1 inserts a separator between codes, 0 emits digits only.
REQ-003 The block SHALL have parameter SEP_CHAR, default 8'h20 (space), the separator character.
REQ-004 The block SHALL have one clock and an asynchronous active-high reset: clk  input  1  clock; rst  input  1  asynchronous active-high reset.
REQ-005 blk_valid  input  1  a code block is present on blk_data.
REQ-006 blk_ready  output  1  the block can accept a code block.
REQ-007 blk_data  input  8 x [0:MSG_LEN-1] unpacked  Polybius codes, each row*10+col, from the encryptor.
REQ-008 out_valid  output  1  out_char holds a valid character.
REQ-009 out_ready  input  1  the consumer accepts out_char.
REQ-010 out_char  output  8  ASCII character.
REQ-011 out_last  output  1  out_char is the final character of the block.
REQ-012 busy  output  1  a block is being serialized.
REQ-013 code_err  output  1  sticky flag: the current or last block held an invalid code.

Function
REQ-014 The FSM SHALL have the states IDLE, HI, LO, SEP; blk_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-015 When blk_valid && blk_ready, the block SHALL latch all MSG_LEN codes into an internal buffer, clear code_err, set index=0, and enter HI.
REQ-016 out_valid SHALL be 1 in HI, LO and SEP and 0 in IDLE, so the first character is valid in the cycle after acceptance.
REQ-017 A code SHALL be valid when its tens digit r and units digit c are both in 1..5 (decimal 11..55, units 1..5); any other code is invalid.
REQ-018 For a valid code: HI SHALL output "0"+r and LO SHALL output "0"+c; for an invalid code: HI and LO SHALL each output "?" (8'h3F), and code_err SHALL set on entry to HI.
REQ-019 State SHALL advance only on out_valid && out_ready; while out_ready=0, out_char, out_last and state SHALL hold unchanged.
REQ-020 HI SHALL advance to LO.
REQ-021 LO SHALL behave as follows when index<MSG_LEN-1: go to SEP if ADD_SEP=1, otherwise increment index and go to HI.
REQ-022 LO SHALL go to IDLE when index==MSG_LEN-1.
REQ-023 SEP SHALL output SEP_CHAR, increment index, and go to HI.
REQ-024 out_last SHALL be 1 only in LO with index==MSG_LEN-1.
REQ-025 Each block SHALL emit exactly 3*MSG_LEN-1 characters when ADD_SEP=1, or 2*MSG_LEN when ADD_SEP=0.
REQ-026 blk_valid SHALL be ignored outside IDLE, and changes on blk_data after acceptance SHALL have no effect.
REQ-027 After the last handshake, blk_ready SHALL be 1 in the next cycle; a block presented in that cycle SHALL be accepted without an idle gap beyond it.
REQ-028 code_err SHALL remain set after the block ends until the next acceptance or reset.
REQ-029 With out_ready tied to 1, throughput SHALL be one character per cycle.
REQ-030 Digit computation SHALL be purely combinational from the latched code (divide/modulo by 10 on 8-bit values); codes 100..255 SHALL be treated as invalid.

Reset
REQ-031 While rst=1, the block SHALL asynchronously force state=IDLE, index=0, code buffer=0, out_valid=0, out_last=0, out_char=8'h00, code_err=0, busy=0; blk_ready SHALL be 1 after deassertion.
REQ-032 A reset mid-block SHALL abort the block; no further characters of that block SHALL be emitted.

Verification
REQ-033 A bench SHALL cover: MSG_LEN=7, ADD_SEP=1, codes 33,15,14,15,31,13,45 ("NEDELCU"), out_ready=1 -> out_char stream "33 15 14 15 31 13 45", 20 characters, out_last only on the final "5", code_err=0.
REQ-034 A bench SHALL cover: the same block with out_ready toggled pseudo-randomly -> identical character sequence, out_char held stable while out_ready=0.
REQ-035 A bench SHALL cover: ADD_SEP=0, codes 11 x 7 -> "11111111111111", 14 characters.
REQ-036 A bench SHALL cover: codes 33,60,16,09,55,12,200 -> "33 ?? ?? ?? 55 12 ??", with code_err=1 from the cycle after the "60" HI is entered until the next acceptance.
REQ-037 A bench SHALL cover: rst asserted after the 5th character -> out_valid=0 immediately, blk_ready=1 after release, and a new block serializes correctly from its first code.
REQ-038 A bench SHALL cover: a second block presented with blk_valid held throughout -> accepted in the cycle after the first block's out_last handshake, and blk_data changes during busy ignored.
